// File: rtl/vmul_xlen_pipe.sv
// SIMD multiplier (MUL/MULH/MULHU/MULHSU) on XLEN-wide operands, 3-stage valid/ready pipeline.
// Optional synchronous pipeline flush port enabled by defining VMUL_FLUSH_EN.
module vmul_xlen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [1:0]      opcode,
    input  logic [1:0]      precision,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mul_out
`ifdef VMUL_FLUSH_EN
    ,
    input  logic            flush
`endif
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHU  = 2'b10,
        OP_MULHSU = 2'b11
    } op_e;

    logic flush_i;
`ifdef VMUL_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    logic v1, v2, v3;
    logic adv1, adv2, adv3, accept;

    logic [XLEN-1:0]   a1, b1;
    op_e               op1, op2;
    logic [1:0]        prec1, prec2, prec_in;
    logic [2*XLEN-1:0] p2;

    logic [3:0][2*XLEN-1:0] prod;
    logic [3:0][XLEN-1:0]   sel;
    logic                   sign_a, sign_b, take_high;

    // A stage may move when it is empty or its successor moves.
    assign adv3     = !v3 || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1 && !flush_i;
    assign accept   = in_valid && in_ready;
    assign out_valid = v3;

    // A 64-bit lane cannot exist in a 32-bit datapath; fold it onto 32-bit lanes.
    assign prec_in = (XLEN == 32 && precision == 2'b11) ? 2'b10 : precision;

    assign sign_a    = (op1 == OP_MULH) || (op1 == OP_MULHSU);
    assign sign_b    = (op1 == OP_MULH);
    assign take_high = (op2 != OP_MUL);

    // Every lane width is built in parallel; precision only picks which set is kept.
    for (genvar w = 0; w < 4; w++) begin : g_width
        localparam int W = 8 << w;
        if (W <= XLEN) begin : g_on
            for (genvar i = 0; i < XLEN / W; i++) begin : g_lane
                logic [2*W-1:0] ext_a, ext_b;
                assign ext_a = {{W{sign_a & a1[i*W+W-1]}}, a1[i*W +: W]};
                assign ext_b = {{W{sign_b & b1[i*W+W-1]}}, b1[i*W +: W]};
                assign prod[w][i*2*W +: 2*W] = ext_a * ext_b;
                assign sel[w][i*W +: W] = take_high ? p2[i*2*W+W +: W] : p2[i*2*W +: W];
            end
        end else begin : g_off
            assign prod[w] = '0;
            assign sel[w]  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples its
    // predecessor's pre-edge value and the pipeline shifts by exactly one stage per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= accept;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // Data moves with the valid bits; a stalled stage simply keeps its contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a1      <= '0;
            b1      <= '0;
            op1     <= OP_MUL;
            prec1   <= '0;
            p2      <= '0;
            op2     <= OP_MUL;
            prec2   <= '0;
            mul_out <= '0;
        end else begin
            if (accept) begin
                a1    <= operand_a;
                b1    <= operand_b;
                op1   <= op_e'(opcode);
                prec1 <= prec_in;
            end
            if (adv2) begin
                p2    <= prod[prec1];
                op2   <= op1;
                prec2 <= prec1;
            end
            if (adv3) begin
                mul_out <= sel[prec2];
            end
        end
    end

endmodule

// File: tb/tb_vmul_xlen_pipe.sv
// Directed self-checking bench for vmul_xlen_pipe: an XLEN=32 instance and an XLEN=64 instance.
// Flush scenario is exercised only when VMUL_FLUSH_EN is defined.
module tb_vmul_xlen_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] operand_a, operand_b, mul_out;
    logic [1:0]  opcode, precision;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [63:0] w_operand_a, w_operand_b, w_mul_out;
    logic [1:0]  w_opcode, w_precision;

`ifdef VMUL_FLUSH_EN
    logic flush, w_flush;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  prec;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vmul_xlen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .opcode(opcode), .precision(precision),
        .out_valid(out_valid), .out_ready(out_ready),
        .mul_out(mul_out)
`ifdef VMUL_FLUSH_EN
        , .flush(flush)
`endif
    );

    vmul_xlen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .operand_a(w_operand_a), .operand_b(w_operand_b),
        .opcode(w_opcode), .precision(w_precision),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .mul_out(w_mul_out)
`ifdef VMUL_FLUSH_EN
        , .flush(w_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] prec,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        opcode    = op;
        precision = prec;
        operand_a = a;
        operand_b = b;
    endtask

    task automatic test_reset();
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid32: got %b want 0", out_valid); end
        if (mul_out !== 32'h0) begin failures++; $display("FAIL reset_mul_out32: got %h want 0", mul_out); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready32: got %b want 1", in_ready); end
        if (w_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid64: got %b want 0", w_out_valid); end
        if (w_mul_out !== 64'h0) begin failures++; $display("FAIL reset_mul_out64: got %h want 0", w_mul_out); end
        if (w_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready64: got %b want 1", w_in_ready); end
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Each vector: accept, confirm nothing after edges N and N+1, result after N+2, gone after deliver.
    task automatic test_lanes();
        vec_t vecs[11];
        vecs[0]  = '{2'b00, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
        vecs[1]  = '{2'b01, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        vecs[2]  = '{2'b10, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        vecs[3]  = '{2'b11, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        vecs[4]  = '{2'b00, 2'b00, 32'h7F02FF80, 32'h02030280, 32'hFE06FE00};
        vecs[5]  = '{2'b01, 2'b00, 32'h80808080, 32'h80808080, 32'h40404040};
        vecs[6]  = '{2'b11, 2'b00, 32'hFF01FF7F, 32'hFFFF0202, 32'hFF00FF00};
        vecs[7]  = '{2'b10, 2'b01, 32'hFFFF0003, 32'hFFFF0005, 32'hFFFE0000};
        vecs[8]  = '{2'b01, 2'b01, 32'hFFFF0003, 32'hFFFF0005, 32'h00000000};
        vecs[9]  = '{2'b11, 2'b01, 32'hFFFF0002, 32'hFFFF8000, 32'hFFFF0001};
        vecs[10] = '{2'b10, 2'b11, 32'h00010000, 32'h00010000, 32'h00000001};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].op, vecs[i].prec, vecs[i].a, vecs[i].b);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL lane_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL lane_early_n[%0d]: out_valid got %b want 0", i, out_valid); end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL lane_early_n1[%0d]: out_valid got %b want 0", i, out_valid); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || mul_out !== vecs[i].exp)
                begin failures++; $display("FAIL lane_result[%0d]: got v=%b %h want v=1 %h", i, out_valid, mul_out, vecs[i].exp); end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL lane_drain[%0d]: out_valid got %b want 0", i, out_valid); end
        end
    endtask

    // Mixed precision/opcode on consecutive edges, results on consecutive cycles.
    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'hFE06FE00;
        exp[1] = 32'hFFFE0000;
        exp[2] = 32'hFFFFFFFF;
        out_ready = 1'b1;
        drive(2'b00, 2'b00, 32'h7F02FF80, 32'h02030280);
        tick();
        drive(2'b10, 2'b01, 32'hFFFF0003, 32'hFFFF0005);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        tick();
        drive(2'b01, 2'b10, 32'hFFFFFFFF, 32'h00000002);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || mul_out !== exp[k])
                begin failures++; $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", k, out_valid, mul_out, exp[k]); end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4];
        exp[0] = 32'd3; exp[1] = 32'd6; exp[2] = 32'd9; exp[3] = 32'd12;
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(2'b00, 2'b10, 32'(k), 32'd3);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept[%0d]: in_ready got %b want 1", k, in_ready); end
            tick();
        end
        drive(2'b00, 2'b10, 32'd4, 32'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || mul_out !== 32'd3)
                begin failures++; $display("FAIL bp_full[%0d]: got rdy=%b v=%b %h want rdy=0 v=1 00000003", k, in_ready, out_valid, mul_out); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_comb_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || mul_out !== exp[k])
                begin failures++; $display("FAIL bp_drain[%0d]: got v=%b %h want v=1 %h", k, out_valid, mul_out, exp[k]); end
            tick();
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(2'b00, 2'b10, 32'(k + 10), 32'd2);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_before: out_valid got %b want 1", out_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mul_out !== 32'h0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL rstmid_async: got v=%b %h rdy=%b want v=0 0 rdy=1", out_valid, mul_out, in_ready); end
        rst = 1'b1;
        out_ready = 1'b1;
        drive(2'b00, 2'b10, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale: out_valid got %b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || mul_out !== 32'd35)
            begin failures++; $display("FAIL rstmid_first: got v=%b %h want v=1 00000023", out_valid, mul_out); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after[%0d]: out_valid got %b want 0", k, out_valid); end
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] wa [3], wb [3], wexp [3];
        logic [1:0]  wop [3], wprec [3];
        wop[0] = 2'b10; wprec[0] = 2'b11; wa[0] = '1; wb[0] = '1; wexp[0] = 64'hFFFFFFFFFFFFFFFE;
        wop[1] = 2'b00; wprec[1] = 2'b00; wa[1] = 64'h0102030405060708; wb[1] = 64'h0202020202020202;
        wexp[1] = 64'h020406080A0C0E10;
        wop[2] = 2'b01; wprec[2] = 2'b10; wa[2] = 64'hFFFFFFFF00000002; wb[2] = 64'h0000000300000003;
        wexp[2] = 64'hFFFFFFFF00000000;
        w_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_in_valid  = 1'b1;
            w_opcode    = wop[i];
            w_precision = wprec[i];
            w_operand_a = wa[i];
            w_operand_b = wb[i];
            tick();
            w_in_valid = 1'b0;
            tick();
            checks++;
            if (w_out_valid !== 1'b0) begin failures++; $display("FAIL x64_early[%0d]: out_valid got %b want 0", i, w_out_valid); end
            tick();
            checks++;
            if (w_out_valid !== 1'b1 || w_mul_out !== wexp[i])
                begin failures++; $display("FAIL x64_result[%0d]: got v=%b %h want v=1 %h", i, w_out_valid, w_mul_out, wexp[i]); end
            tick();
        end
    endtask

`ifdef VMUL_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b1;
        drive(2'b00, 2'b10, 32'd2, 32'd2);
        tick();
        drive(2'b00, 2'b10, 32'd3, 32'd3);
        tick();
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_quiet[%0d]: out_valid got %b want 0", k, out_valid); end
            tick();
        end
        drive(2'b00, 2'b10, 32'd6, 32'd7);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || mul_out !== 32'd42)
            begin failures++; $display("FAIL flush_after: got v=%b %h want v=1 0000002a", out_valid, mul_out); end
        tick();
    endtask
`endif

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        operand_a   = '0;
        operand_b   = '0;
        opcode      = '0;
        precision   = '0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
        w_operand_a = '0;
        w_operand_b = '0;
        w_opcode    = '0;
        w_precision = '0;
`ifdef VMUL_FLUSH_EN
        flush   = 1'b0;
        w_flush = 1'b0;
`endif
        test_reset();
        test_lanes();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_xlen64();
`ifdef VMUL_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
